capture_sequencer: RTL and testbench
====================================

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter NUM_SAMPLES, default 1000, samples per capture window and per readout.
REQ-002 Parameter FIR_LATENCY, default 64, filter pipeline fill cycles before arming is allowed.
REQ-003 Parameter HOLDOFF, default 1000, idle cycles after a readout completes before the next arm is accepted.
REQ-004 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 arm  in  1  one-cycle request to arm for one capture.
REQ-007 trigger_in  in  1  raw, asynchronous trigger.
REQ-008 sample_data  in  14  unsigned filtered sample at sample_index from the waveform buffer, valid combinationally.
REQ-009 tx_ready  in  1  UART transmitter can accept a byte.
REQ-010 capture_trigger  out  1  one-cycle pulse that starts the waveform buffer capture.
REQ-011 sample_index  out  10  waveform buffer read address.
REQ-012 tx_data  out  8  byte to the UART.
REQ-013 tx_valid  out  1  tx_data is valid.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when the last byte of a frame transfers.

Function
REQ-016 States SHALL be WARMUP, IDLE, ARMED, CAPTURE, SEND_HDR, SEND_HI, SEND_LO and HOLDOFF.
REQ-017 WARMUP SHALL last FIR_LATENCY cycles after reset, then go to IDLE; arm during WARMUP is dropped.
REQ-018 IDLE SHALL go to ARMED on arm=1; arm in any other state is ignored.
REQ-019 trigger_in SHALL pass through a 2-flop synchronizer and then a rising-edge detector.
REQ-020 In ARMED, an edge SHALL pulse capture_trigger and enter CAPTURE, so capture_trigger is high exactly 3 cycles after trigger_in rises.
REQ-021 Edges outside ARMED are ignored; trigger_in held high does not re-fire.
REQ-022 CAPTURE SHALL last exactly NUM_SAMPLES cycles, counted from the capture_trigger cycle, then go to SEND_HDR.
REQ-023 A frame SHALL be 8'hA5, then for index 0..NUM_SAMPLES-1: {2'b00, sample_data[13:8]} then sample_data[7:0].
REQ-024 Frame length SHALL be 2*NUM_SAMPLES+1 bytes.
REQ-025 A byte SHALL transfer only when tx_valid=1 and tx_ready=1 in the same cycle.
REQ-026 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-027 tx_valid SHALL be high throughout SEND_HDR, SEND_HI and SEND_LO, allowing back-to-back transfers.
REQ-028 sample_index SHALL advance only on a SEND_LO transfer.
REQ-029 sample_index SHALL be 0 outside SEND states and SHALL NOT exceed NUM_SAMPLES-1.
REQ-030 The final SEND_LO transfer SHALL pulse done, clear sample_index and enter HOLDOFF.
REQ-031 HOLDOFF SHALL last HOLDOFF cycles, then go to IDLE.
REQ-032 All counters SHALL be sized with $clog2 of their parameter and SHALL NOT wrap.

Reset
REQ-033 Reset SHALL force state WARMUP, clear all counters and synchronizer flops, and drive every output to 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no further tx_valid and no done.

Structure
REQ-035 Package dsp_ctrl_pkg SHALL hold the state enum, HEADER_BYTE=8'hA5 and SAMPLE_W=14.
REQ-036 Sub-module edge_sync SHALL implement the synchronizer and rising-edge detector.
REQ-037 The FSM and counters SHALL be in capture_sequencer; outputs SHALL be registered except sample_index decode.

Verification (NUM_SAMPLES=4, FIR_LATENCY=8, HOLDOFF=16)
REQ-038 Arm at cycle 3 -> ignored, busy stays 1, IDLE reached at cycle 8.
REQ-039 Arm, trigger rise, samples 0x3FFF, 0x0001, 0x2A5A, 0x1234 with tx_ready=1 -> capture_trigger 3 cycles after the rise, then 9 bytes A5 3F FF 00 01 2A 5A 12 34 and done on the last byte.
REQ-040 Same capture with tx_ready toggling 1/0 -> identical byte sequence, tx_data stable while stalled, no byte lost or duplicated.
REQ-041 Trigger in IDLE, a second trigger during CAPTURE, and arm during SEND -> no extra capture_trigger and no state change.
REQ-042 Reset asserted after the 4th byte -> outputs 0 next cycle, then WARMUP for 8 cycles.
REQ-043 Arm in the cycle done pulses and 10 cycles later -> both ignored; arm at 16 cycles after done -> ARMED.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the capture/readout controller.
//   SAMPLE_W     : width of one filtered sample from the waveform buffer
//   HEADER_BYTE  : first byte of every readout frame
//   seq_state_t  : sequencer state encoding
package dsp_ctrl_pkg;

   localparam int         SAMPLE_W    = 14;
   localparam logic [7:0] HEADER_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_WARMUP,
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_SEND_HDR,
      ST_SEND_HI,
      ST_SEND_LO,
      ST_HOLDOFF
   } seq_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for an
// asynchronous trigger line.
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, clears all flops
//   din  : raw asynchronous input
//   rise : one-cycle pulse on a synchronized 0->1 transition
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic sync_p0;
   logic sync_p1;
   logic prev_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         prev_p2 <= 1'b0;
      end else begin
         // stage 0/1: metastability filter; stage 2: delayed copy for edge detect
         sync_p0 <= din;
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
      end
   end

   assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/capture_sequencer.sv
// Arms on request, waits for a trigger edge, runs a fixed-length capture
// window and then streams the captured samples to a UART as a framed byte
// sequence: header, then high byte / low byte per sample.
//   sys_clk         : single clock, rising edge
//   reset           : asynchronous active-high reset
//   arm             : one-cycle request to arm (honoured in IDLE only)
//   trigger_in      : raw asynchronous trigger
//   sample_data     : sample at sample_index, valid combinationally
//   tx_ready        : UART can accept a byte
//   capture_trigger : one-cycle pulse starting the waveform buffer capture
//   sample_index    : waveform buffer read address
//   tx_data/tx_valid: byte stream to the UART (valid/ready handshake)
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse after the last byte of a frame
module capture_sequencer
   import dsp_ctrl_pkg::*;
#(
   parameter int NUM_SAMPLES = 1000,
   parameter int FIR_LATENCY = 64,
   parameter int HOLDOFF     = 1000
) (
   input  logic                sys_clk,
   input  logic                reset,
   input  logic                arm,
   input  logic                trigger_in,
   input  logic [SAMPLE_W-1:0] sample_data,
   input  logic                tx_ready,
   output logic                capture_trigger,
   output logic [9:0]          sample_index,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   output logic                busy,
   output logic                done
);

   localparam int IDX_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
   localparam int WARM_W = (FIR_LATENCY > 1) ? $clog2(FIR_LATENCY) : 1;
   localparam int HOLD_W = (HOLDOFF > 1)     ? $clog2(HOLDOFF)     : 1;

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SAMPLES - 1);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(FIR_LATENCY - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

   function automatic logic [7:0] hi_byte(input logic [SAMPLE_W-1:0] s);
      return {2'b00, s[SAMPLE_W-1:8]};
   endfunction

   function automatic logic [7:0] lo_byte(input logic [SAMPLE_W-1:0] s);
      return s[7:0];
   endfunction

   seq_state_t        state, state_nxt;
   logic [WARM_W-1:0] warm_cnt, warm_cnt_nxt;
   logic [IDX_W-1:0]  cap_cnt, cap_cnt_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [7:0]        tx_data_nxt;
   logic              tx_valid_nxt;
   logic              cap_trig_nxt;
   logic              done_nxt;
   logic              busy_nxt;
   logic              trig_rise;
   logic              xfer;

   edge_sync u_edge_sync (
      .clk  (sys_clk),
      .rst  (reset),
      .din  (trigger_in),
      .rise (trig_rise)
   );

   assign xfer = tx_valid & tx_ready;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state           <= ST_WARMUP;
         warm_cnt        <= '0;
         cap_cnt         <= '0;
         hold_cnt        <= '0;
         idx             <= '0;
         tx_data         <= '0;
         tx_valid        <= 1'b0;
         capture_trigger <= 1'b0;
         done            <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state           <= state_nxt;
         warm_cnt        <= warm_cnt_nxt;
         cap_cnt         <= cap_cnt_nxt;
         hold_cnt        <= hold_cnt_nxt;
         idx             <= idx_nxt;
         tx_data         <= tx_data_nxt;
         tx_valid        <= tx_valid_nxt;
         capture_trigger <= cap_trig_nxt;
         done            <= done_nxt;
         busy            <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      warm_cnt_nxt = warm_cnt;
      cap_cnt_nxt  = cap_cnt;
      hold_cnt_nxt = hold_cnt;
      idx_nxt      = idx;
      tx_data_nxt  = tx_data;
      cap_trig_nxt = 1'b0;
      done_nxt     = 1'b0;

      case (state)
         ST_WARMUP: begin
            if (warm_cnt == WARM_LAST) begin
               warm_cnt_nxt = '0;
               state_nxt    = ST_IDLE;
            end else begin
               warm_cnt_nxt = warm_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            if (arm) state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (trig_rise) begin
               cap_trig_nxt = 1'b1;
               cap_cnt_nxt  = '0;
               state_nxt    = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            // the capture_trigger cycle is count 0
            if (cap_cnt == IDX_LAST) begin
               cap_cnt_nxt = '0;
               idx_nxt     = '0;
               tx_data_nxt = HEADER_BYTE;
               state_nxt   = ST_SEND_HDR;
            end else begin
               cap_cnt_nxt = cap_cnt + 1'b1;
            end
         end
         ST_SEND_HDR: begin
            if (xfer) begin
               tx_data_nxt = hi_byte(sample_data);
               state_nxt   = ST_SEND_HI;
            end
         end
         ST_SEND_HI: begin
            if (xfer) begin
               tx_data_nxt = lo_byte(sample_data);
               state_nxt   = ST_SEND_LO;
            end
         end
         ST_SEND_LO: begin
            if (xfer) begin
               if (idx == IDX_LAST) begin
                  idx_nxt      = '0;
                  done_nxt     = 1'b1;
                  hold_cnt_nxt = '0;
                  state_nxt    = ST_HOLDOFF;
               end else begin
                  // sample_index already presents idx+1 during this transfer
                  idx_nxt     = idx + 1'b1;
                  tx_data_nxt = hi_byte(sample_data);
                  state_nxt   = ST_SEND_HI;
               end
            end
         end
         ST_HOLDOFF: begin
            if (hold_cnt == HOLD_LAST) begin
               hold_cnt_nxt = '0;
               state_nxt    = ST_IDLE;
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_WARMUP;
      endcase

      tx_valid_nxt = (state_nxt == ST_SEND_HDR) || (state_nxt == ST_SEND_HI) ||
                     (state_nxt == ST_SEND_LO);
      busy_nxt     = (state_nxt != ST_IDLE);
   end

   // Read address decode. The registered tx_data needs the next sample's
   // high byte at the edge that completes a low-byte transfer, so the
   // address looks one sample ahead during exactly that cycle.
   always_comb begin
      sample_index = '0;
      if ((state == ST_SEND_HDR) || (state == ST_SEND_HI)) begin
         sample_index = 10'(idx);
      end else if (state == ST_SEND_LO) begin
         if (xfer && (idx != IDX_LAST)) sample_index = 10'(idx + 1'b1);
         else                           sample_index = 10'(idx);
      end
   end

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer (NUM_SAMPLES=4, FIR_LATENCY=8,
// HOLDOFF=16). Stimulus pushes expected bytes and capture_trigger cycles;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_capture_sequencer;

   localparam int NS = 4;
   localparam int FL = 8;
   localparam int HO = 16;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        arm;
   logic        trigger_in;
   logic [13:0] sample_data;
   logic        tx_ready;
   logic        capture_trigger;
   logic [9:0]  sample_index;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        done;

   capture_sequencer #(
      .NUM_SAMPLES (NS),
      .FIR_LATENCY (FL),
      .HOLDOFF     (HO)
   ) dut (
      .sys_clk         (sys_clk),
      .reset           (reset),
      .arm             (arm),
      .trigger_in      (trigger_in),
      .sample_data     (sample_data),
      .tx_ready        (tx_ready),
      .capture_trigger (capture_trigger),
      .sample_index    (sample_index),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .busy            (busy),
      .done            (done)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [13:0] mem [NS];
   logic [7:0]  exp_frame [9] = '{8'hA5, 8'h3F, 8'hFF, 8'h00, 8'h01,
                                  8'h2A, 8'h5A, 8'h12, 8'h34};

   logic [7:0] byte_q [$];
   int         cap_q  [$];

   // waveform buffer model
   always_comb begin
      sample_data = 14'h0;
      if (sample_index < 10'(NS)) sample_data = mem[sample_index[1:0]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push_frame(input int nbytes);
      for (int i = 0; i < nbytes; i++) byte_q.push_back(exp_frame[i]);
   endtask

   task automatic wait_done(input bit toggle, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (done) begin
            dcyc = cyc;
            break;
         end
         if (toggle) tx_ready = ~tx_ready;
      end
      tx_ready = 1'b1;
      if (dcyc < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: done not seen within 400 cycles (cycle %0d)", cyc);
         dcyc = cyc;
      end
   endtask

   // monitor
   int         frame_bytes   = 0;
   int         xfer_total    = 0;
   int         last_xfer_cyc = -10;
   logic       prev_stall    = 1'b0;
   logic [7:0] prev_data     = 8'h0;

   always @(negedge sys_clk) begin
      if (reset) begin
         frame_bytes = 0;
         prev_stall  = 1'b0;
      end else begin
         if (prev_stall) check("stall_hold", tx_data, prev_data);
         if (capture_trigger) begin
            if (cap_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_capture: capture_trigger high, none expected (cycle %0d)", cyc);
            end else begin
               check("capture_cycle", cyc, cap_q.pop_front());
            end
         end
         if (tx_valid && tx_ready) begin
            if (byte_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_byte: got 0x%0h, no byte expected (cycle %0d)", tx_data, cyc);
            end else begin
               check("tx_byte", tx_data, byte_q.pop_front());
            end
            check("index_range", sample_index < 10'(NS), 1'b1);
            frame_bytes++;
            xfer_total++;
            last_xfer_cyc = cyc;
         end
         if (done) begin
            check("done_frame_len", frame_bytes, 9);
            check("done_after_last", last_xfer_cyc, cyc - 1);
            frame_bytes = 0;
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t, d, x0;
      mem[0] = 14'h3FFF;
      mem[1] = 14'h0001;
      mem[2] = 14'h2A5A;
      mem[3] = 14'h1234;
      reset = 1'b1; arm = 1'b0; trigger_in = 1'b0; tx_ready = 1'b0;
      repeat (3) tick();
      check("reset_outputs", {capture_trigger, sample_index, tx_data, tx_valid, busy, done}, 22'h0);

      // warmup: arm at cycle 3 dropped, IDLE at cycle 8
      reset = 1'b0;
      base = cyc;
      wait_until(base + 3);
      arm = 1'b1; tick(); arm = 1'b0;
      check("warmup_busy_c4", busy, 1'b1);
      wait_until(base + 7);
      check("warmup_busy_c7", busy, 1'b1);
      wait_until(base + 8);
      check("idle_busy_c8", busy, 1'b0);
      check("idle_index", sample_index, 10'h0);
      check("idle_valid", tx_valid, 1'b0);

      // full frame, tx_ready held high
      tx_ready = 1'b1;
      arm = 1'b1; tick(); arm = 1'b0;
      check("armed_busy", busy, 1'b1);
      tick(); tick();
      trigger_in = 1'b1; t = cyc;
      cap_q.push_back(t + 3);
      push_frame(9);
      wait_done(1'b0, d);
      check("done_latency", d, t + 16);

      // trigger held high across arming does not fire; then stalled frame
      wait_until(d + 20);
      arm = 1'b1; tick(); arm = 1'b0;
      repeat (6) tick();
      check("held_trigger_no_fire", busy, 1'b1);
      trigger_in = 1'b0; tick(); tick();
      trigger_in = 1'b1; t = cyc;
      cap_q.push_back(t + 3);
      push_frame(9);
      wait_done(1'b1, d);

      // trigger in IDLE ignored
      wait_until(d + 20);
      trigger_in = 1'b0; tick(); tick();
      trigger_in = 1'b1;
      repeat (5) tick();
      check("idle_trigger_ignored", busy, 1'b0);

      // second trigger in CAPTURE and arm in SEND ignored
      trigger_in = 1'b0;
      arm = 1'b1; tick(); arm = 1'b0;
      tick();
      trigger_in = 1'b1; t = cyc;
      cap_q.push_back(t + 3);
      push_frame(9);
      tick(); trigger_in = 1'b0;
      wait_until(t + 3); trigger_in = 1'b1;
      wait_until(t + 9);
      arm = 1'b1; tick(); arm = 1'b0;
      wait_done(1'b0, d);
      check("done_latency_2", d, t + 16);

      // arm during HOLDOFF ignored, accepted 16 cycles after done
      arm = 1'b1; tick(); arm = 1'b0;
      wait_until(d + 10);
      arm = 1'b1; tick(); arm = 1'b0;
      wait_until(d + 15);
      check("holdoff_busy_d15", busy, 1'b1);
      wait_until(d + 16);
      check("holdoff_idle_d16", busy, 1'b0);
      arm = 1'b1; tick(); arm = 1'b0;
      check("rearm_busy_d17", busy, 1'b1);

      // reset after the 4th byte aborts the frame
      trigger_in = 1'b0; tick(); tick();
      trigger_in = 1'b1; t = cyc;
      cap_q.push_back(t + 3);
      push_frame(4);
      x0 = xfer_total;
      for (int i = 0; i < 100 && xfer_total < x0 + 4; i++) tick();
      check("four_bytes_sent", xfer_total, x0 + 4);
      reset = 1'b1;
      tick();
      check("reset_midframe_outputs",
            {capture_trigger, sample_index, tx_data, tx_valid, busy, done}, 22'h0);
      reset = 1'b0;
      base = cyc;
      wait_until(base + 7);
      check("rewarm_busy_c7", busy, 1'b1);
      wait_until(base + 8);
      check("rewarm_idle_c8", busy, 1'b0);
      check("rewarm_no_valid", tx_valid, 1'b0);

      repeat (4) tick();
      check("byte_queue_drained", byte_q.size(), 0);
      check("capture_queue_drained", cap_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
